// File: rtl/av2_recon_writer_pkg.sv
// Shared types for the reconstructed-frame writer: read FSM states,
// burst descriptor layout and the default beat stride.
package av2_recon_writer_pkg;

    localparam int BEAT_BYTES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } rd_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_desc_t;

endpackage

// File: rtl/av2_sync_fifo.sv
// Single-clock FIFO with full/empty/level; pushes on full and pops on
// empty are ignored. Ports: clk, rst_n, push/din, pop/dout, full, empty, level.
module av2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/av2_recon_frame_writer.sv
// Buffers reconstructed beats, coalesces address-contiguous beats into
// bursts and writes them over a command + write-data interface.
// Ports: recon_* write stream in, mem_cmd_* / mem_w* burst interface out,
// writer_done / overflow_err / busy / fifo_level status.
module av2_recon_frame_writer
    import av2_recon_writer_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int MAX_BURST     = 8,
    parameter int BEAT_BYTES    = BEAT_BYTES_DEF,
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [127:0]                  recon_data,
    input  logic [31:0]                   recon_addr,
    input  logic                          recon_wr_en,
    input  logic                          tile_done,
    output logic                          mem_cmd_valid,
    input  logic                          mem_cmd_ready,
    output logic [31:0]                   mem_cmd_addr,
    output logic [7:0]                    mem_cmd_len,
    output logic [127:0]                  mem_wdata,
    output logic                          mem_wvalid,
    input  logic                          mem_wready,
    output logic                          mem_wlast,
    output logic                          writer_done,
    output logic                          overflow_err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam int TW = $clog2(FLUSH_TIMEOUT) + 1;
    localparam int DW = 128 + 32;

    // data FIFO
    logic          d_push, d_pop, d_full, d_empty;
    logic [DW-1:0] d_head;

    // descriptor FIFO
    logic          l_push, l_pop, l_full, l_empty;
    burst_desc_t   l_din, l_head;
    logic [$clog2(FIFO_DEPTH):0] l_level;

    // open run
    logic          run_open;
    logic [31:0]   run_start, run_last;
    logic [CW-1:0] run_cnt;
    logic [TW-1:0] idle_cnt;

    logic          new_run, close_a, close_b, timeout;
    logic [31:0]   cur_start;
    logic [CW-1:0] cur_cnt;
    burst_desc_t   desc_a, desc_b;

    // second descriptor closed in the same cycle waits here one cycle
    logic          pend_v, pend_nv;
    burst_desc_t   pend_d, pend_nd;

    logic          flush_pending;

    rd_state_t     state, state_n;
    logic [31:0]   cmd_addr;
    logic [7:0]    cmd_len;
    logic [7:0]    beat_idx;

    logic          unused_bits;

    assign d_push = recon_wr_en && !d_full;

    av2_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (d_push),
        .din   ({recon_data, recon_addr}),
        .pop   (d_pop),
        .dout  (d_head),
        .full  (d_full),
        .empty (d_empty),
        .level (fifo_level)
    );

    av2_sync_fifo #(.WIDTH($bits(burst_desc_t)), .DEPTH(FIFO_DEPTH)) u_len_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (l_push),
        .din   (l_din),
        .pop   (l_pop),
        .dout  (l_head),
        .full  (l_full),
        .empty (l_empty),
        .level (l_level)
    );

    assign unused_bits = ^{d_head[31:0], l_full, l_level};

    // Run tracking: close_a closes the previous run when a new one starts,
    // close_b closes the run as it stands after this cycle's push.
    always_comb begin
        new_run   = !run_open
                 || (recon_addr != run_last + 32'(BEAT_BYTES))
                 || (run_cnt == CW'(MAX_BURST));
        close_a   = d_push && new_run && run_open;
        desc_a    = '{addr: run_start, len: 8'(run_cnt - 1'b1)};
        cur_start = (d_push && new_run) ? recon_addr : run_start;
        if (!d_push)     cur_cnt = run_cnt;
        else if (new_run) cur_cnt = CW'(1);
        else             cur_cnt = run_cnt + 1'b1;
        timeout   = !d_push && run_open
                 && (idle_cnt == TW'(FLUSH_TIMEOUT - 1));
        if (d_push)
            close_b = tile_done || (cur_cnt == CW'(MAX_BURST));
        else
            close_b = run_open && (tile_done || timeout);
        desc_b    = '{addr: cur_start, len: 8'(cur_cnt - 1'b1)};
    end

    // A pending descriptor implies no open run, so at most two
    // descriptors compete in any cycle.
    always_comb begin
        l_push  = 1'b0;
        l_din   = desc_b;
        pend_nv = pend_v;
        pend_nd = pend_d;
        if (pend_v) begin
            l_push  = 1'b1;
            l_din   = pend_d;
            pend_nv = close_a || close_b;
            pend_nd = close_a ? desc_a : desc_b;
        end else if (close_a) begin
            l_push  = 1'b1;
            l_din   = desc_a;
            pend_nv = close_b;
            pend_nd = desc_b;
        end else if (close_b) begin
            l_push  = 1'b1;
            l_din   = desc_b;
            pend_nv = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_open  <= 1'b0;
            run_start <= '0;
            run_last  <= '0;
            run_cnt   <= '0;
            idle_cnt  <= '0;
            pend_v    <= 1'b0;
            pend_d    <= '0;
        end else begin
            pend_v <= pend_nv;
            pend_d <= pend_nd;
            if (d_push) begin
                run_start <= cur_start;
                run_last  <= recon_addr;
                run_cnt   <= close_b ? '0 : cur_cnt;
                run_open  <= !close_b;
                idle_cnt  <= '0;
            end else if (run_open) begin
                if (close_b) begin
                    run_open <= 1'b0;
                    run_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err  <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            if (recon_wr_en && d_full) overflow_err <= 1'b1;
            if (tile_done)        flush_pending <= 1'b1;
            else if (writer_done) flush_pending <= 1'b0;
        end
    end

    assign writer_done = flush_pending && !run_open && !pend_v
                      && d_empty && l_empty && (state == IDLE);

    assign busy = !d_empty || run_open || pend_v || !l_empty
               || (state != IDLE);

    assign mem_cmd_addr = cmd_addr;
    assign mem_cmd_len  = cmd_len;

    // Read FSM: one command, then its beats, strictly in sequence.
    always_comb begin
        state_n       = state;
        l_pop         = 1'b0;
        d_pop         = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_wvalid    = 1'b0;
        mem_wlast     = 1'b0;
        mem_wdata     = '0;
        unique case (state)
            IDLE: begin
                if (!l_empty) begin
                    l_pop   = 1'b1;
                    state_n = CMD;
                end
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) state_n = DATA;
            end
            DATA: begin
                mem_wvalid = !d_empty;
                mem_wdata  = d_empty ? '0 : d_head[DW-1:32];
                mem_wlast  = !d_empty && (beat_idx == cmd_len);
                d_pop      = mem_wvalid && mem_wready;
                if (d_pop && mem_wlast) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_addr <= '0;
            cmd_len  <= '0;
            beat_idx <= '0;
        end else begin
            state <= state_n;
            if (l_pop) begin
                cmd_addr <= l_head.addr;
                cmd_len  <= l_head.len;
            end
            if (state == CMD && mem_cmd_ready) beat_idx <= '0;
            else if (d_pop)                    beat_idx <= beat_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_av2_recon_frame_writer.sv
// Self-checking bench for av2_recon_frame_writer: directed and random
// beat streams compared against a queue-based burst model.
module tb_av2_recon_frame_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] recon_data = '0;
    logic [31:0]  recon_addr = '0;
    logic         recon_wr_en = 1'b0;
    logic         tile_done = 1'b0;
    logic         mem_cmd_valid;
    logic         mem_cmd_ready = 1'b1;
    logic [31:0]  mem_cmd_addr;
    logic [7:0]   mem_cmd_len;
    logic [127:0] mem_wdata;
    logic         mem_wvalid;
    logic         mem_wready = 1'b1;
    logic         mem_wlast;
    logic         writer_done;
    logic         overflow_err;
    logic         busy;
    logic [4:0]   fifo_level;

    always #5 clk = ~clk;

    av2_recon_frame_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .recon_data    (recon_data),
        .recon_addr    (recon_addr),
        .recon_wr_en   (recon_wr_en),
        .tile_done     (tile_done),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_len   (mem_cmd_len),
        .mem_wdata     (mem_wdata),
        .mem_wvalid    (mem_wvalid),
        .mem_wready    (mem_wready),
        .mem_wlast     (mem_wlast),
        .writer_done   (writer_done),
        .overflow_err  (overflow_err),
        .busy          (busy),
        .fifo_level    (fifo_level)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic         last;
        logic [127:0] d;
    } beat_t;

    // reference model: runs as queues of beats, closed runs become
    // expected commands and expected beats
    logic [39:0]  exp_cmd [$];
    beat_t        exp_beat [$];
    logic [127:0] run_q [$];
    logic [31:0]  m_start, m_last;
    int           m_idle = 0;
    bit           m_ovf = 0;
    int           exp_done = 0, done_seen = 0;
    int           n_pushed = 0, n_beats = 0, n_cmds = 0;
    bit           rnd_ready = 0;

    function automatic void close_run();
        exp_cmd.push_back({m_start, 8'(run_q.size() - 1)});
        foreach (run_q[i])
            exp_beat.push_back({(i == run_q.size() - 1), run_q[i]});
        run_q.delete();
        m_idle = 0;
    endfunction

    task automatic tick(input bit wr, input logic [31:0] a,
                        input logic [127:0] d, input bit td);
        bit full;
        recon_wr_en = wr;
        recon_addr  = a;
        recon_data  = d;
        tile_done   = td;
        full = (n_pushed - n_beats) >= 16;
        @(posedge clk);
        if (wr && full) begin
            m_ovf = 1;
        end else if (wr) begin
            n_pushed++;
            if (run_q.size() > 0 &&
                (a != m_last + 32'd16 || run_q.size() == 8))
                close_run();
            if (run_q.size() == 0) m_start = a;
            run_q.push_back(d);
            m_last = a;
            m_idle = 0;
            if (run_q.size() == 8) close_run();
        end else if (run_q.size() > 0) begin
            m_idle++;
            if (m_idle == 64) close_run();
        end
        if (td) begin
            if (run_q.size() > 0) close_run();
            exp_done++;
        end
        #1;
        recon_wr_en = 1'b0;
        tile_done   = 1'b0;
        if (rnd_ready) begin
            mem_cmd_ready = 1'($urandom_range(0, 1));
            mem_wready    = ($urandom % 4) != 0;
        end
    endtask

    function automatic logic [127:0] rdata();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            tick(1, base + 32'(i * 16), rdata(), 0);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_cmd.size() == 0 && exp_beat.size() == 0 &&
                done_seen == exp_done && run_q.size() == 0)
                break;
            tick(0, '0, '0, 0);
        end
        chk({tag, "_cmds_left"}, exp_cmd.size(), 0);
        chk({tag, "_beats_left"}, exp_beat.size(), 0);
        chk({tag, "_done_cnt"}, done_seen, exp_done);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_cmd_valid && mem_cmd_ready) begin
                n_cmds++;
                if (exp_cmd.size() == 0)
                    chk("cmd_unexpected", exp_cmd.size(), 1);
                else
                    chk("cmd", {mem_cmd_addr, mem_cmd_len},
                        exp_cmd.pop_front());
            end
            if (mem_wvalid && mem_wready) begin
                n_beats++;
                if (exp_beat.size() == 0)
                    chk("beat_unexpected", exp_beat.size(), 1);
                else
                    chk("beat", {mem_wlast, mem_wdata},
                        exp_beat.pop_front());
            end
            if (writer_done) begin
                done_seen++;
                chk("done_drained", exp_cmd.size() + exp_beat.size(), 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, b0;
        logic [31:0] na;
        bit hit;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_valid", mem_cmd_valid, 0);
        chk("rst_wvalid", mem_wvalid, 0);
        chk("rst_done", writer_done, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        rst_n = 1'b1;

        // one full burst
        send_run(32'h0, 8);
        tick(0, '0, '0, 1);
        wait_drain("s1", 100);

        // break in contiguity, then tile_done
        send_run(32'h100, 5);
        tick(1, 32'h400, rdata(), 0);
        tick(0, '0, '0, 1);
        wait_drain("s2", 100);

        // non-contiguous beat arriving together with tile_done
        send_run(32'h600, 3);
        tick(1, 32'h900, rdata(), 1);
        wait_drain("s2b", 100);

        // 20 contiguous beats, last run closed only by tile_done
        send_run(32'h0, 20);
        repeat (5) tick(0, '0, '0, 0);
        chk("s3_open_busy", busy, 1);
        tick(0, '0, '0, 1);
        wait_drain("s3", 200);

        // idle timeout closes the run, no writer_done
        c0 = n_cmds;
        send_run(32'h200, 3);
        repeat (62) tick(0, '0, '0, 0);
        chk("to_early", n_cmds, c0);
        repeat (6) tick(0, '0, '0, 0);
        chk("to_fire", n_cmds, c0 + 1);
        wait_drain("s4", 100);
        chk("to_no_done", done_seen, exp_done);

        // overflow with write channel stalled
        mem_wready = 1'b0;
        send_run(32'h1000, 17);
        tick(0, '0, '0, 0);
        chk("ovf_flag", overflow_err, m_ovf);
        chk("ovf_level", fifo_level, n_pushed - n_beats);
        mem_wready = 1'b1;
        tick(0, '0, '0, 1);
        wait_drain("s5", 200);
        chk("ovf_sticky", overflow_err, m_ovf);

        // randomized streams with random back-pressure
        for (int r = 0; r < 3; r++) begin
            rnd_ready = 1;
            na = $urandom & 32'hffff_fff0;
            for (int i = 0; i < 200; i++) begin
                if ((n_pushed - n_beats) < 12 && $urandom_range(0, 9) < 6) begin
                    if ($urandom_range(0, 3) == 0)
                        na = $urandom & 32'hffff_fff0;
                    tick(1, na, rdata(), 0);
                    na = na + 32'd16;
                end else begin
                    tick(0, '0, '0, 0);
                end
            end
            tick(0, '0, '0, 1);
            wait_drain("rnd", 3000);
            rnd_ready = 0;
            mem_cmd_ready = 1'b1;
            mem_wready = 1'b1;
        end

        // reset in the middle of a data phase
        b0 = n_beats;
        send_run(32'h3000, 8);
        tick(0, '0, '0, 1);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            #2;
            hit = (n_beats - b0) >= 3;
        end
        chk("mid_reach", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_cmd_valid", mem_cmd_valid, 0);
        chk("mid_wvalid", {mem_wvalid, mem_wlast, mem_wdata}, 0);
        chk("mid_done", writer_done, 0);
        chk("mid_ovf", overflow_err, 0);
        chk("mid_busy", busy, 0);
        chk("mid_level", fifo_level, 0);
        chk("mid_cmd", {mem_cmd_addr, mem_cmd_len}, 0);
        exp_cmd.delete();
        exp_beat.delete();
        run_q.delete();
        m_idle = 0;
        m_ovf = 0;
        n_pushed = 0;
        n_beats = 0;
        exp_done = 0;
        done_seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 32'h5000, rdata(), 0);
        tick(0, '0, '0, 1);
        wait_drain("post_rst", 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
